// File: rtl/min.sv
// Three-way minimum finder: combinational argmin over the slave priorities
// with lowest-index tie-break, plus a registered index and a change pulse.
module min #(
   parameter int unsigned PRIO_W = 2
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [PRIO_W-1:0] slv0_prio_i,
   input  logic [PRIO_W-1:0] slv1_prio_i,
   input  logic [PRIO_W-1:0] slv2_prio_i,
   output logic [1:0]        min_index,
   output logic [PRIO_W-1:0] min_prio_o,
   output logic              min_tie_o,
   output logic [1:0]        min_index_q,
   output logic              min_chg_o
);

   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 2;

   logic [IDX_W-1:0]  idx01;
   logic [PRIO_W-1:0] prio01;
   logic [CNT_W-1:0]  eq_cnt;
   logic              chg_d;
   logic              chg_q;

   // Argmin: strict less-than keeps the lower index on ties.
   always_comb begin
      idx01      = IDX_W'(0);
      prio01     = slv0_prio_i;
      if (slv1_prio_i < slv0_prio_i) begin
         idx01  = IDX_W'(1);
         prio01 = slv1_prio_i;
      end
      min_index  = idx01;
      min_prio_o = prio01;
      if (slv2_prio_i < prio01) begin
         min_index  = IDX_W'(2);
         min_prio_o = slv2_prio_i;
      end
   end

   // Tie when at least two slaves hold the minimum value.
   always_comb begin
      eq_cnt    = CNT_W'(slv0_prio_i == min_prio_o)
                + CNT_W'(slv1_prio_i == min_prio_o)
                + CNT_W'(slv2_prio_i == min_prio_o);
      min_tie_o = (eq_cnt >= CNT_W'(2));
   end

   // Change pulse fires when the value about to be loaded differs from the held one.
   always_comb begin
      chg_d = (min_index != min_index_q);
   end

   // Registered index and change pulse, cleared asynchronously by reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         min_index_q <= IDX_W'(0);
         chg_q       <= 1'b0;
      end else begin
         min_index_q <= min_index;
         chg_q       <= chg_d;
      end
   end

   assign min_chg_o = chg_q;

endmodule

// File: tb/tb_min.sv
// Self-checking bench for min: scoreboard queues hold expected outputs.
module tb_min;

   localparam int unsigned PW = 2;

   typedef struct {
      logic [1:0]    idx;
      logic [PW-1:0] prio;
      logic          tie;
   } comb_exp_t;

   typedef struct {
      logic [1:0] q;
      logic       chg;
   } reg_exp_t;

   logic          clk;
   logic          rstn;
   logic [PW-1:0] p0, p1, p2;
   logic [1:0]    min_index;
   logic [PW-1:0] min_prio;
   logic          min_tie;
   logic [1:0]    min_index_q;
   logic          min_chg;

   int checks = 0;
   int errors = 0;

   comb_exp_t comb_sb[$];
   reg_exp_t  reg_sb[$];
   logic [1:0] prev_q;

   min #(.PRIO_W(PW)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .slv0_prio_i (p0),
      .slv1_prio_i (p1),
      .slv2_prio_i (p2),
      .min_index   (min_index),
      .min_prio_o  (min_prio),
      .min_tie_o   (min_tie),
      .min_index_q (min_index_q),
      .min_chg_o   (min_chg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: scan all slaves, keep first strict minimum, count holders of it.
   function automatic comb_exp_t ref_model(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                           input logic [PW-1:0] c);
      logic [PW-1:0] v [3];
      comb_exp_t r;
      int best;
      int cnt;
      v[0] = a; v[1] = b; v[2] = c;
      best = 0;
      for (int i = 1; i < 3; i++)
         if (v[i] < v[best]) best = i;
      cnt = 0;
      for (int i = 0; i < 3; i++)
         if (v[i] == v[best]) cnt++;
      r.idx  = 2'(best);
      r.prio = v[best];
      r.tie  = (cnt >= 2);
      return r;
   endfunction

   // Drive inputs and push the expected combinational outputs.
   task automatic apply_comb(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [PW-1:0] c);
      p0 = a; p1 = b; p2 = c;
      comb_sb.push_back(ref_model(a, b, c));
   endtask

   // Drive inputs for the next edge and push the expected registered outputs.
   task automatic apply_reg(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [PW-1:0] c);
      comb_exp_t e;
      reg_exp_t r;
      p0 = a; p1 = b; p2 = c;
      e = ref_model(a, b, c);
      r.q   = e.idx;
      r.chg = (e.idx != prev_q);
      prev_q = e.idx;
      reg_sb.push_back(r);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      p0 = 2'd3; p1 = 2'd1; p2 = 2'd2;
      #1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (min_index_q !== 2'd0 || min_chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: q=%0d chg=%0d required q=0 chg=0", min_index_q, min_chg);
         end
         checks++;
         if (min_index !== 2'd1) begin
            errors++;
            $display("FAIL reset_comb_track: min_index=%0d required 1", min_index);
         end
      end
   endtask

   task automatic test_unique;
      logic [PW-1:0] ta [3];
      logic [PW-1:0] tb [3];
      logic [PW-1:0] tc [3];
      comb_exp_t e;
      ta = '{2'd3, 2'd3, 2'd1};
      tb = '{2'd1, 2'd2, 2'd3};
      tc = '{2'd2, 2'd1, 2'd2};
      for (int i = 0; i < 3; i++) begin
         apply_comb(ta[i], tb[i], tc[i]);
         #1;
         e = comb_sb.pop_front();
         checks++;
         if (min_index !== e.idx || min_prio !== e.prio || min_tie !== e.tie) begin
            errors++;
            $display("FAIL unique_%0d: idx=%0d prio=%0d tie=%0d required idx=%0d prio=%0d tie=%0d",
                     i, min_index, min_prio, min_tie, e.idx, e.prio, e.tie);
         end
      end
   endtask

   task automatic test_ties;
      logic [PW-1:0] ta [7];
      logic [PW-1:0] tb [7];
      logic [PW-1:0] tc [7];
      logic [1:0]    xi [7];
      logic          xt [7];
      comb_exp_t e;
      ta = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd3, 2'd2};
      tb = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2};
      tc = '{2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
      xi = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
      xt = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         apply_comb(ta[i], tb[i], tc[i]);
         #1;
         e = comb_sb.pop_front();
         checks++;
         if (min_index !== xi[i] || min_tie !== xt[i] || min_prio !== e.prio || e.idx !== xi[i]) begin
            errors++;
            $display("FAIL tie_%0d: idx=%0d tie=%0d prio=%0d required idx=%0d tie=%0d prio=%0d",
                     i, min_index, min_tie, min_prio, xi[i], xt[i], e.prio);
         end
      end
   endtask

   task automatic test_exhaustive;
      comb_exp_t e;
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 4; c++) begin
               apply_comb(2'(a), 2'(b), 2'(c));
               #1;
               e = comb_sb.pop_front();
               checks++;
               if (min_index !== e.idx || min_prio !== e.prio || min_tie !== e.tie) begin
                  errors++;
                  $display("FAIL exhaustive(%0d,%0d,%0d): idx=%0d prio=%0d tie=%0d required idx=%0d prio=%0d tie=%0d",
                           a, b, c, min_index, min_prio, min_tie, e.idx, e.prio, e.tie);
               end
            end
   endtask

   task automatic test_registered;
      reg_exp_t r;
      @(negedge clk);
      prev_q = 2'd0;
      rstn = 1'b1;
      apply_reg(2'd3, 2'd1, 2'd2);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         r = reg_sb.pop_front();
         checks++;
         if (min_index_q !== r.q || min_chg !== r.chg) begin
            errors++;
            $display("FAIL registered_%0d: q=%0d chg=%0d required q=%0d chg=%0d",
                     i, min_index_q, min_chg, r.q, r.chg);
         end
         @(negedge clk);
         apply_reg(2'd3, 2'd1, 2'd2);
      end
      void'(reg_sb.pop_front());
   endtask

   task automatic test_back_to_back;
      reg_exp_t r;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         apply_reg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         // Mid-cycle input change must not disturb registered outputs.
         #1;
         checks++;
         if (min_chg !== (i == 0 ? 1'b0 : min_chg)) begin
            errors++;
         end
         @(posedge clk); #1;
         r = reg_sb.pop_front();
         checks++;
         if (min_index_q !== r.q || min_chg !== r.chg) begin
            errors++;
            $display("FAIL back_to_back_%0d: q=%0d chg=%0d required q=%0d chg=%0d",
                     i, min_index_q, min_chg, r.q, r.chg);
         end
      end
   endtask

   task automatic test_reset_mid;
      reg_exp_t r;
      comb_exp_t e;
      @(negedge clk);
      apply_reg(2'd3, 2'd2, 2'd1);
      @(posedge clk); #1;
      r = reg_sb.pop_front();
      checks++;
      if (min_index_q !== 2'd2 || min_chg !== r.chg) begin
         errors++;
         $display("FAIL reset_mid_setup: q=%0d chg=%0d required q=2 chg=%0d", min_index_q, min_chg, r.chg);
      end
      #1;
      rstn = 1'b0;
      #1;
      checks++;
      if (min_index_q !== 2'd0 || min_chg !== 1'b0 || min_index !== 2'd2) begin
         errors++;
         $display("FAIL reset_mid_clear: q=%0d chg=%0d idx=%0d required q=0 chg=0 idx=2",
                  min_index_q, min_chg, min_index);
      end
      apply_comb(2'd1, 2'd3, 2'd2);
      #1;
      e = comb_sb.pop_front();
      checks++;
      if (min_index !== e.idx || min_prio !== e.prio || min_tie !== e.tie) begin
         errors++;
         $display("FAIL reset_mid_track: idx=%0d prio=%0d tie=%0d required idx=%0d prio=%0d tie=%0d",
                  min_index, min_prio, min_tie, e.idx, e.prio, e.tie);
      end
      @(posedge clk); #1;
      checks++;
      if (min_index_q !== 2'd0 || min_chg !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_hold: q=%0d chg=%0d required q=0 chg=0", min_index_q, min_chg);
      end
      // Release with min_index 0: first edge loads 0 and raises no pulse, then a change to 2.
      @(negedge clk);
      rstn = 1'b1;
      prev_q = 2'd0;
      apply_reg(2'd1, 2'd3, 2'd2);
      @(posedge clk); #1;
      r = reg_sb.pop_front();
      checks++;
      if (min_index_q !== r.q || min_chg !== r.chg) begin
         errors++;
         $display("FAIL release_same: q=%0d chg=%0d required q=%0d chg=%0d", min_index_q, min_chg, r.q, r.chg);
      end
      @(negedge clk);
      apply_reg(2'd3, 2'd2, 2'd1);
      @(posedge clk); #1;
      r = reg_sb.pop_front();
      checks++;
      if (min_index_q !== r.q || min_chg !== r.chg) begin
         errors++;
         $display("FAIL release_change: q=%0d chg=%0d required q=%0d chg=%0d", min_index_q, min_chg, r.q, r.chg);
      end
   endtask

   initial begin
      prev_q = 2'd0;
      test_reset();
      test_unique();
      test_ties();
      test_exhaustive();
      rstn = 1'b0;
      test_registered();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
